// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter: N_REQ valid/ready beat streams share one
// registered output slot. A granted packet keeps the output until its last beat.
module stream_rr_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 32,
    localparam int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [SRC_W-1:0]        out_src,
    output logic                    busy
);

    // Handshake: a beat moves on any cycle where valid and ready are both high;
    // ready never depends on data, and the output slot is free when it is empty
    // or being drained in the same cycle.

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SRC_W-1:0]  r_ptr;
    logic [SRC_W-1:0]  w_ptr_nxt;
    logic [SRC_W-1:0]  r_owner;
    logic [SRC_W-1:0]  w_owner_nxt;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic [SRC_W-1:0]  r_out_src;

    logic [SRC_W-1:0]  w_winner;
    logic              w_found;
    logic [SRC_W-1:0]  w_sel;
    logic              w_grant;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic [SRC_W-1:0]  w_sel_inc;

    // Round-robin search starting at r_ptr, wrapping modulo N_REQ.
    always_comb begin : p_search
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && req_valid[SRC_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        w_sel       = (r_state == ST_LOCKED) ? r_owner : w_winner;
        w_grant     = (r_state == ST_LOCKED) | w_found;
        w_slot_free = ~r_out_valid | out_ready;
        w_accept    = w_grant & w_slot_free & req_valid[w_sel];
        w_sel_last  = req_last[w_sel];
        w_sel_data  = req_data[int'(w_sel)*DATA_W +: DATA_W];
        w_sel_inc   = (w_sel == SRC_W'(N_REQ - 1)) ? '0 : w_sel + SRC_W'(1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // FSM next state: the pointer only advances when a packet completes.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_accept) begin
            if (w_sel_last) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = w_sel_inc;
            end else if (r_state == ST_IDLE) begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_winner;
            end
        end
    end

    // FSM outputs
    always_comb begin
        req_ready = '0;
        if (w_grant && w_slot_free) begin
            req_ready[w_sel] = 1'b1;
        end
        busy = (r_state == ST_LOCKED);
    end

    // Output slot: a new accept overwrites the draining beat with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed vector bench for stream_rr_arbiter with N_REQ=4: a table of
// per-cycle inputs and expected results, plus reset and fairness sequences.
module tb_stream_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [SRC_W-1:0]        out_src;
    logic                    busy;

    int n_assert;
    int n_fail;

    stream_rr_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0]  valid;
        logic [N_REQ-1:0]  last;
        logic              ordy;
        logic [N_REQ-1:0]  exp_ready;
        logic              exp_ov;
        logic [SRC_W-1:0]  exp_src;
        logic              exp_last;
        logic              exp_busy;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vq[$];

    // Beat payload of requester i during vector v: unique per (v, i).
    function automatic logic [DATA_W-1:0] mk_data(input int v, input int i);
        return {4'(i + 1), 20'h0, 8'(v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // dvec < 0: expected data is this vector's own payload of exp_src.
    task automatic add_vec(input logic [3:0] valid, input logic [3:0] last, input logic ordy,
                           input logic [3:0] exp_ready, input logic exp_ov, input int exp_src,
                           input logic exp_last, input logic exp_busy, input int dvec);
        vec_t v;
        int   dv;
        dv          = (dvec < 0) ? vq.size() : dvec;
        v.valid     = valid;
        v.last      = last;
        v.ordy      = ordy;
        v.exp_ready = exp_ready;
        v.exp_ov    = exp_ov;
        v.exp_src   = SRC_W'(exp_src);
        v.exp_last  = exp_last;
        v.exp_busy  = exp_busy;
        v.exp_data  = mk_data(dv, exp_src);
        vq.push_back(v);
    endtask

    task automatic drive(input int tag, input logic [3:0] valid, input logic [3:0] last,
                         input logic ordy);
        req_valid = valid;
        req_last  = last;
        out_ready = ordy;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = mk_data(tag, i);
        end
    endtask

    initial begin
        int cnt[N_REQ];
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // valid   last   rdy  ready  ov src last busy dvec
        // single-beat packets, pointer walks 0,1,2,3,0,1
        add_vec(4'b0001, 4'b1111, 1, 4'b0001, 1, 0, 1, 0, -1);  // 0
        add_vec(4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1, 0, -1);  // 1
        add_vec(4'b1111, 4'b1111, 1, 4'b0100, 1, 2, 1, 0, -1);  // 2
        add_vec(4'b1111, 4'b1111, 1, 4'b1000, 1, 3, 1, 0, -1);  // 3
        add_vec(4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1, 0, -1);  // 4
        add_vec(4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1, 0, -1);  // 5
        // 3-beat packet from req2 while everyone is valid, then req3
        add_vec(4'b1111, 4'b0000, 1, 4'b0100, 1, 2, 0, 1, -1);  // 6
        add_vec(4'b1111, 4'b0000, 1, 4'b0100, 1, 2, 0, 1, -1);  // 7
        add_vec(4'b1111, 4'b0100, 1, 4'b0100, 1, 2, 1, 0, -1);  // 8
        add_vec(4'b1111, 4'b1111, 1, 4'b1000, 1, 3, 1, 0, -1);  // 9
        // 5-cycle downstream stall, then drain+accept in one cycle
        add_vec(4'b0011, 4'b1111, 1, 4'b0001, 1, 0, 1, 0, -1);  // 10
        add_vec(4'b0011, 4'b1111, 0, 4'b0000, 1, 0, 1, 0, 10);  // 11
        add_vec(4'b0011, 4'b1111, 0, 4'b0000, 1, 0, 1, 0, 10);  // 12
        add_vec(4'b0011, 4'b1111, 0, 4'b0000, 1, 0, 1, 0, 10);  // 13
        add_vec(4'b0011, 4'b1111, 0, 4'b0000, 1, 0, 1, 0, 10);  // 14
        add_vec(4'b0011, 4'b1111, 0, 4'b0000, 1, 0, 1, 0, 10);  // 15
        add_vec(4'b0011, 4'b1111, 1, 4'b0010, 1, 1, 1, 0, -1);  // 16
        add_vec(4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, -1);  // 17
        // owner req0 drops valid for 3 cycles while req1 waits
        add_vec(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 1, -1);  // 18
        add_vec(4'b0010, 4'b0000, 1, 4'b0001, 0, 0, 0, 1, -1);  // 19
        add_vec(4'b0010, 4'b0000, 1, 4'b0001, 0, 0, 0, 1, -1);  // 20
        add_vec(4'b0010, 4'b0000, 1, 4'b0001, 0, 0, 0, 1, -1);  // 21
        add_vec(4'b0011, 4'b0001, 1, 4'b0001, 1, 0, 1, 0, -1);  // 22
        add_vec(4'b0011, 4'b1111, 1, 4'b0010, 1, 1, 1, 0, -1);  // 23
        // pointer at idle requester skips ahead, then wraps 3 -> 0
        add_vec(4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 1, 0, -1);  // 24
        add_vec(4'b1001, 4'b1111, 1, 4'b0001, 1, 0, 1, 0, -1);  // 25

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_src", 32'(out_src), 0);
        chk("reset out_last", 32'(out_last), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[n]) begin
            drive(n, vq[n].valid, vq[n].last, vq[n].ordy);
            #1;
            chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(vq[n].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(vq[n].exp_ov));
            chk($sformatf("v%0d busy", n), 32'(busy), 32'(vq[n].exp_busy));
            if (vq[n].exp_ov) begin
                chk($sformatf("v%0d out_src", n), 32'(out_src), 32'(vq[n].exp_src));
                chk($sformatf("v%0d out_last", n), 32'(out_last), 32'(vq[n].exp_last));
                chk($sformatf("v%0d out_data", n), out_data, vq[n].exp_data);
            end
        end

        // Reset mid-packet: ptr is 1 here, so req2 wins and locks.
        drive(100, 4'b0100, 4'b0000, 1'b1);
        #1;
        chk("lock req_ready", 32'(req_ready), 32'(4'b0100));
        @(posedge clk);
        #1;
        chk("lock busy", 32'(busy), 1);
        chk("lock out_src", 32'(out_src), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 0);
        chk("async rst busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(101, 4'b1010, 4'b1111, 1'b1);
        #1;
        chk("post rst req_ready", 32'(req_ready), 32'(4'b0010));
        @(posedge clk);
        #1;
        chk("post rst out_valid", 32'(out_valid), 1);
        chk("post rst out_src", 32'(out_src), 1);
        chk("post rst out_data", out_data, mk_data(101, 1));

        // Fairness: all valid, single-beat; ptr is 2, 8 packets -> 2 each.
        for (int i = 0; i < N_REQ; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            drive(200 + c, 4'b1111, 4'b1111, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("fair c%0d out_valid", c), 32'(out_valid), 1);
            chk($sformatf("fair c%0d out_src", c), 32'(out_src), 32'((c + 2) % N_REQ));
            cnt[out_src]++;
        end
        for (int i = 0; i < N_REQ; i++) begin
            chk($sformatf("fair grants req%0d", i), 32'(cnt[i]), 2);
        end

        drive(300, 4'b0000, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        chk("final drain out_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one registered valid/ready output stage among N_REQ requesters.
- Requesters present 32-bit beats grouped into packets delimited by a last flag.
- Arbitration is round-robin per packet; a granted packet holds the output until its last beat.
- Sits in front of a single downstream consumer, for example a pipeline register chain or a shared FIFO write port.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- DATA_W, 32: beat data width.
- SRC_W, $clog2(N_REQ): width of the source index (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester beat valid
- req_ready  output  N_REQ  per-requester beat accept
- req_data  input  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  input  N_REQ  per-requester last beat of packet
- out_valid  output  1  registered beat valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  registered beat data
- out_last  output  1  registered last flag
- out_src  output  SRC_W  index of the requester that supplied the current beat
- busy  output  1  high while state is LOCKED

Behaviour:
- Reset (asynchronous, clk not required): all of the following take effect immediately.
  - out_valid, out_data, out_last, out_src and busy go to 0.
  - Round-robin pointer ptr goes to 0; state goes to IDLE.
  - A packet interrupted by reset is discarded; after reset, arbitration restarts from requester 0.
- Output slot:
  - slot_free = ~out_valid | out_ready.
  - Holds one beat; no internal FIFO.
  - When out_valid=1 and out_ready=0, out_data, out_last and out_src hold stable.
- Accept rule:
  - A beat from requester i is accepted on a cycle where req_valid[i] & req_ready[i].
  - On the next edge it loads out_data, out_last and out_src=i, and out_valid goes to 1.
  - Latency is one cycle; throughput is one beat per cycle while out_ready=1.
  - If the slot drains with no new accept, out_valid goes to 0.
- IDLE state:
  - winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo wrap).
  - req_ready[winner] = slot_free; all other req_ready are 0.
  - If no req_valid is set, all req_ready are 0 and nothing changes.
  - Accepted beat with req_last=1: stay IDLE; ptr <= (winner+1) mod N_REQ.
  - Accepted beat with req_last=0: go to LOCKED, owner <= winner, ptr unchanged.
- LOCKED state:
  - req_ready[owner] = slot_free; all other req_ready are 0, regardless of their valid.
  - Owner deasserting req_valid mid-packet keeps the lock; no timeout.
  - Accepted owner beat with req_last=1: go to IDLE; ptr <= (owner+1) mod N_REQ.
  - busy = (state==LOCKED).
- Grant logic:
  - req_ready depends combinationally on req_valid and out_ready only.
  - There is no combinational path from req_data to any output.
- Boundary conditions:
  - Pointer wraps from N_REQ-1 to 0.
  - When ptr points at an idle requester, the search skips to the next valid one.
  - Drain and accept on the same cycle (out_valid=1, out_ready=1, new accept): the new beat replaces the old one; out_valid stays 1 with no bubble.
  - Single-beat packets (last=1 on the first beat) never enter LOCKED.
  - Fairness: with all requesters continuously valid, each is granted exactly once per N_REQ packets.

Test Plan:
- Reset, then req0 sends 0x11111111 with last=1 while out_ready=1 -> out_valid=1 one cycle later, out_data=0x11111111, out_src=0, out_last=1; ptr becomes 1.
- All four requesters valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0,... with one beat per cycle and no bubbles.
- req2 sends a 3-beat packet (0xA0, 0xA1, 0xA2; last on 0xA2) while req0, req1 and req3 stay valid -> the three beats appear contiguously with out_src=2 and busy=1 until after the last beat is accepted; the next grant goes to req3.
- out_ready held 0 for 5 cycles with a beat in the slot -> out_data and out_src stable; all req_ready=0; on release, the next beat follows in the same cycle the slot drains.
- Owner drops req_valid for 3 cycles mid-packet while req1 is valid -> req_ready[1] stays 0 and the lock is held; the packet resumes and completes.
- rst_n asserted mid-packet while LOCKED -> out_valid=0 and busy=0 immediately; after release, req1 and req3 both valid -> req1 is granted first (ptr=0).
